// File: rtl/dcache_tag_ctrl.sv
// Sequencing controller for the 64-set data-cache tag/flag RAM: init sweep,
// lookup, dirty-victim writeback, line fill, tag update and index invalidate.
module dcache_tag_ctrl #(
  parameter int PABITS = 36
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [PABITS-1:0] cpu_addr,
  output logic              cpu_ready,
  input  logic              inv_req,
  input  logic [5:0]        inv_index,
  output logic              inv_done,
  output logic              init_done,
  output logic              wb_req,
  output logic [PABITS-1:0] wb_addr,
  input  logic              wb_ack,
  output logic              fill_req,
  output logic [PABITS-1:0] fill_addr,
  input  logic              fill_ack,
  output logic [5:0]        tr_index,
  output logic [PABITS-11:0] tr_tag_cmp,
  output logic [PABITS-11:0] tr_tag_set,
  output logic              tr_write,
  output logic              tr_valid,
  output logic              tr_dirty,
  input  logic [PABITS-11:0] tr_match_tag,
  input  logic              tr_match_hit,
  input  logic              tr_match_valid,
  input  logic              tr_match_dirty
);

  localparam int TW = PABITS - 10;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LOOKUP = 3'd2,
    S_WB     = 3'd3,
    S_FILL   = 3'd4,
    S_UPDATE = 3'd5,
    S_CLEAR  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [TW-1:0] vtag_q, vtag_d;
  logic          write_q, write_d;
  logic          inv_q, inv_d;
  logic          init_done_q, init_done_d;

  // Byte offset within the line never reaches the tag RAM.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[3:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      vtag_q      <= '0;
      write_q     <= 1'b0;
      inv_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      vtag_q      <= vtag_d;
      write_q     <= write_d;
      inv_q       <= inv_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done  = init_done_q;
  assign tr_tag_cmp = tag_q;
  assign wb_addr    = {vtag_q, idx_q, 4'b0000};
  assign fill_addr  = {tag_q, idx_q, 4'b0000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    vtag_d      = vtag_q;
    write_d     = write_q;
    inv_d       = inv_q;
    init_done_d = init_done_q;
    cpu_ready   = 1'b0;
    inv_done    = 1'b0;
    wb_req      = 1'b0;
    fill_req    = 1'b0;
    tr_index    = idx_q;
    tr_tag_set  = '0;
    tr_write    = 1'b0;
    tr_valid    = 1'b0;
    tr_dirty    = 1'b0;
    // Outputs stay quiet while reset is held, even though the state is INIT.
    if (reset) begin
      case (state_q)
        S_INIT: begin
          tr_write = 1'b1;
          tr_index = cnt_q;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end
        end
        S_IDLE: begin
          tr_index = inv_req ? inv_index : cpu_addr[9:4];
          if (inv_req) begin
            inv_d   = 1'b1;
            idx_d   = inv_index;
            write_d = 1'b0;
            state_d = S_LOOKUP;
          end else if (cpu_req) begin
            inv_d   = 1'b0;
            idx_d   = cpu_addr[9:4];
            tag_d   = cpu_addr[PABITS-1:10];
            write_d = cpu_write;
            state_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (inv_q) begin
            if (tr_match_valid && tr_match_dirty) begin
              vtag_d  = tr_match_tag;
              state_d = S_WB;
            end else begin
              state_d = S_CLEAR;
            end
          end else if (tr_match_hit) begin
            cpu_ready = 1'b1;
            state_d   = S_IDLE;
            // First store to a clean resident line marks it dirty in place.
            if (write_q && !tr_match_dirty) begin
              tr_write   = 1'b1;
              tr_tag_set = tag_q;
              tr_valid   = 1'b1;
              tr_dirty   = 1'b1;
            end
          end else if (tr_match_valid && tr_match_dirty) begin
            vtag_d  = tr_match_tag;
            state_d = S_WB;
          end else begin
            state_d = S_FILL;
          end
        end
        S_WB: begin
          wb_req = 1'b1;
          if (wb_ack) state_d = inv_q ? S_CLEAR : S_FILL;
        end
        S_FILL: begin
          fill_req = 1'b1;
          if (fill_ack) state_d = S_UPDATE;
        end
        S_UPDATE: begin
          tr_write   = 1'b1;
          tr_tag_set = tag_q;
          tr_valid   = 1'b1;
          tr_dirty   = write_q;
          cpu_ready  = 1'b1;
          state_d    = S_IDLE;
        end
        S_CLEAR: begin
          tr_write = 1'b1;
          inv_done = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: tag RAM model, directed table, randomized ops
// against a set-level cache model, and reset/throughput sequences.
module tb_dcache_tag_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [35:0] cpu_addr = '0;
  logic        cpu_ready;
  logic        inv_req = 1'b0;
  logic [5:0]  inv_index = '0;
  logic        inv_done, init_done;
  logic        wb_req, fill_req;
  logic [35:0] wb_addr, fill_addr;
  logic        wb_ack = 1'b0, fill_ack = 1'b0;
  logic [5:0]  tr_index;
  logic [25:0] tr_tag_cmp, tr_tag_set, tr_match_tag;
  logic        tr_write, tr_valid, tr_dirty;
  logic        tr_match_hit, tr_match_valid, tr_match_dirty;

  dcache_tag_ctrl #(.PABITS(36)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .inv_req(inv_req), .inv_index(inv_index), .inv_done(inv_done), .init_done(init_done),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_ack(fill_ack),
    .tr_index(tr_index), .tr_tag_cmp(tr_tag_cmp), .tr_tag_set(tr_tag_set),
    .tr_write(tr_write), .tr_valid(tr_valid), .tr_dirty(tr_dirty),
    .tr_match_tag(tr_match_tag), .tr_match_hit(tr_match_hit),
    .tr_match_valid(tr_match_valid), .tr_match_dirty(tr_match_dirty)
  );

  always #5 clock = ~clock;

  // Tag RAM: registered read index, flags/tag visible the cycle after.
  logic        ram_v [64];
  logic        ram_d [64];
  logic [25:0] ram_t [64];
  logic [5:0]  rd_idx = '0;
  logic        scramble = 1'b1;

  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < 64; i++) begin
        ram_v[i] <= 1'($urandom);
        ram_d[i] <= 1'($urandom);
        ram_t[i] <= 26'($urandom);
      end
    end else if (tr_write) begin
      ram_v[tr_index] <= tr_valid;
      ram_d[tr_index] <= tr_dirty;
      ram_t[tr_index] <= tr_tag_set;
    end
    rd_idx <= tr_index;
  end

  assign tr_match_tag   = ram_t[rd_idx];
  assign tr_match_valid = ram_v[rd_idx];
  assign tr_match_dirty = ram_d[rd_idx];
  assign tr_match_hit   = ram_v[rd_idx] && (ram_t[rd_idx] == tr_tag_cmp);

  // Reference cache state, one entry per set.
  bit          m_v [64];
  bit          m_d [64];
  logic [25:0] m_t [64];

  int vectors = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_expect(input bit inv, input bit wr, input logic [35:0] addr,
                              input logic [5:0] iidx, input int dw, input int df,
                              output bit e_wb, output logic [35:0] e_wba,
                              output bit e_fill, output logic [35:0] e_fa,
                              output int e_lat, output int e_wr);
    logic [5:0]  ix;
    logic [25:0] tg;
    ix     = inv ? iidx : addr[9:4];
    tg     = addr[35:10];
    e_wb   = m_v[ix] && m_d[ix];
    e_wba  = {m_t[ix], ix, 4'h0};
    e_fill = 1'b0;
    e_fa   = '0;
    e_wr   = 1;
    if (inv) begin
      e_lat = e_wb ? 3 + dw : 2;
    end else if (m_v[ix] && m_t[ix] == tg) begin
      e_wb  = 1'b0;
      e_lat = 1;
      e_wr  = (wr && !m_d[ix]) ? 1 : 0;
    end else begin
      e_fill = 1'b1;
      e_fa   = {tg, ix, 4'h0};
      e_lat  = e_wb ? 4 + dw + df : 3 + df;
    end
  endtask

  task automatic model_apply(input bit inv, input bit wr, input logic [35:0] addr,
                             input logic [5:0] iidx, output logic [5:0] ix);
    logic [25:0] tg;
    ix = inv ? iidx : addr[9:4];
    tg = addr[35:10];
    if (inv) begin
      m_v[ix] = 1'b0;
      m_d[ix] = 1'b0;
    end else if (m_v[ix] && m_t[ix] == tg) begin
      if (wr) m_d[ix] = 1'b1;
    end else begin
      m_v[ix] = 1'b1;
      m_d[ix] = wr;
      m_t[ix] = tg;
    end
  endtask

  task automatic check_line(input int id, input logic [5:0] ix);
    chk($sformatf("op%0d_ram_valid", id), 64'(ram_v[ix]), 64'(m_v[ix]));
    chk($sformatf("op%0d_ram_dirty", id), 64'(ram_d[ix]), 64'(m_d[ix]));
    if (m_v[ix]) chk($sformatf("op%0d_ram_tag", id), 64'(ram_t[ix]), 64'(m_t[ix]));
  endtask

  // Issue one request from IDLE and play the memory side.
  task automatic run_op(input int id, input bit inv, input bit wr, input bit other,
                        input logic [35:0] addr, input logic [5:0] iidx,
                        input int dw, input int df,
                        input bit e_wb, input logic [35:0] e_wba,
                        input bit e_fill, input logic [35:0] e_fa,
                        input int e_lat, input int e_wr);
    int done_n, rdy_cnt, inv_cnt, writes, both, wb_first, fill_first, unstable;
    bit wb_seen, fill_seen;
    logic [35:0] got_wba, got_fa;
    done_n = -1; rdy_cnt = 0; inv_cnt = 0; writes = 0; both = 0; unstable = 0;
    wb_first = 0; fill_first = 0; wb_seen = 0; fill_seen = 0; got_wba = '0; got_fa = '0;
    inv_req   = inv;
    inv_index = iidx;
    cpu_req   = !inv || other;
    cpu_write = wr;
    cpu_addr  = addr;
    @(posedge clock);
    @(negedge clock);
    inv_req = 1'b0;
    cpu_req = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      wb_ack   = 1'b0;
      fill_ack = 1'b0;
      if (done_n >= 0 && n > done_n + 1) break;
      if (tr_write) writes++;
      if (wb_req && fill_req) both++;
      if (wb_req) begin
        if (!wb_seen) begin wb_seen = 1; wb_first = n; got_wba = wb_addr; end
        else if (wb_addr !== got_wba) unstable++;
        if (n - wb_first == dw) wb_ack = 1'b1;
      end
      if (fill_req) begin
        if (!fill_seen) begin fill_seen = 1; fill_first = n; got_fa = fill_addr; end
        else if (fill_addr !== got_fa) unstable++;
        if (n - fill_first == df) fill_ack = 1'b1;
      end
      if (cpu_ready) rdy_cnt++;
      if (inv_done) inv_cnt++;
      if (done_n < 0 && (inv ? inv_done : cpu_ready)) done_n = n;
      @(posedge clock);
      @(negedge clock);
    end
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
    chk($sformatf("op%0d_latency", id), 64'(done_n), 64'(e_lat));
    chk($sformatf("op%0d_ready_pulses", id), 64'(rdy_cnt), inv ? 64'd0 : 64'd1);
    chk($sformatf("op%0d_inv_pulses", id), 64'(inv_cnt), inv ? 64'd1 : 64'd0);
    chk($sformatf("op%0d_wb_seen", id), 64'(wb_seen), 64'(e_wb));
    if (e_wb) chk($sformatf("op%0d_wb_addr", id), 64'(got_wba), 64'(e_wba));
    chk($sformatf("op%0d_fill_seen", id), 64'(fill_seen), 64'(e_fill));
    if (e_fill) chk($sformatf("op%0d_fill_addr", id), 64'(got_fa), 64'(e_fa));
    chk($sformatf("op%0d_tr_writes", id), 64'(writes), 64'(e_wr));
    chk($sformatf("op%0d_req_overlap_or_unstable", id), 64'(both + unstable), 64'd0);
  endtask

  task automatic model_op(input int id, input bit inv, input bit wr, input bit other,
                          input logic [35:0] addr, input logic [5:0] iidx,
                          input int dw, input int df);
    bit e_wb, e_fill;
    logic [35:0] e_wba, e_fa;
    int e_lat, e_wr;
    logic [5:0] ix;
    model_expect(inv, wr, addr, iidx, dw, df, e_wb, e_wba, e_fill, e_fa, e_lat, e_wr);
    run_op(id, inv, wr, other, addr, iidx, dw, df, e_wb, e_wba, e_fill, e_fa, e_lat, e_wr);
    model_apply(inv, wr, addr, iidx, ix);
    check_line(id, ix);
  endtask

  // Entered with reset low; releases it and follows the 64-cycle sweep.
  task automatic reset_sweep(input bit poke_cpu, input bit late_ack);
    int bad, nvalid;
    bad = 0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_outputs", 64'({cpu_ready, inv_done, init_done, wb_req, fill_req, tr_write}), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_fill_addr", 64'(fill_addr), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (!(tr_write && tr_index == 6'(k) && !tr_valid && !tr_dirty) ||
          init_done || cpu_ready || inv_done || wb_req || fill_req) bad++;
      cpu_req  = poke_cpu && (k == 10);
      fill_ack = late_ack && (k == 5);
      @(negedge clock);
    end
    cpu_req  = 1'b0;
    fill_ack = 1'b0;
    #1;
    chk("sweep_pattern", 64'(bad), 64'd0);
    chk("init_done_at_64", 64'(init_done), 64'd1);
    chk("post_sweep_quiet", 64'({tr_write, cpu_ready, fill_req, wb_req}), 64'd0);
    nvalid = 0;
    for (int i = 0; i < 64; i++) if (ram_v[i] || ram_d[i]) nvalid++;
    chk("sweep_cleared_sets", 64'(nvalid), 64'd0);
    for (int i = 0; i < 64; i++) begin m_v[i] = 1'b0; m_d[i] = 1'b0; m_t[i] = '0; end
  endtask

  typedef struct {
    bit inv; bit wr; bit other;
    logic [35:0] addr; logic [5:0] iidx;
    int dw; int df;
    bit e_wb; logic [35:0] e_wba;
    bit e_fill; logic [35:0] e_fa;
    int e_lat; int e_wr;
  } vec_t;

  vec_t        tbl [13];
  logic [25:0] tags [3];
  logic [5:0]  idxs [4];
  logic [5:0]  lix;
  logic [35:0] ra, a_addr, b_addr, c_addr;
  bit          seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0, 0, 36'h0_0000_1230, 6'h00, 0, 3, 0, 36'h0,           1, 36'h0_0000_1230, 6, 1};
    tbl[1]  = '{0, 0, 0, 36'h0_0000_1230, 6'h00, 0, 0, 0, 36'h0,           0, 36'h0,           1, 0};
    tbl[2]  = '{0, 1, 0, 36'h0_0000_1234, 6'h00, 0, 0, 0, 36'h0,           0, 36'h0,           1, 1};
    tbl[3]  = '{0, 0, 0, 36'h0_0000_5230, 6'h00, 1, 1, 1, 36'h0_0000_1230, 1, 36'h0_0000_5230, 6, 1};
    tbl[4]  = '{0, 1, 0, 36'h0_0000_5238, 6'h00, 0, 0, 0, 36'h0,           0, 36'h0,           1, 1};
    tbl[5]  = '{1, 0, 0, 36'h0,           6'h23, 2, 0, 1, 36'h0_0000_5230, 0, 36'h0,           5, 1};
    tbl[6]  = '{0, 0, 0, 36'h0_0000_5230, 6'h00, 0, 0, 0, 36'h0,           1, 36'h0_0000_5230, 3, 1};
    tbl[7]  = '{1, 0, 0, 36'h0,           6'h23, 0, 0, 0, 36'h0,           0, 36'h0,           2, 1};
    tbl[8]  = '{1, 0, 1, 36'h0_0000_1230, 6'h10, 0, 0, 0, 36'h0,           0, 36'h0,           2, 1};
    tbl[9]  = '{0, 1, 0, 36'h9_8765_4320, 6'h00, 0, 2, 0, 36'h0,           1, 36'h9_8765_4320, 5, 1};
    tbl[10] = '{0, 1, 0, 36'h9_8765_4328, 6'h00, 0, 0, 0, 36'h0,           0, 36'h0,           1, 0};
    tbl[11] = '{0, 0, 0, 36'h1_0000_0320, 6'h00, 0, 0, 1, 36'h9_8765_4320, 1, 36'h1_0000_0320, 4, 1};
    tbl[12] = '{0, 0, 0, 36'h1_0000_0324, 6'h00, 0, 0, 0, 36'h0,           0, 36'h0,           1, 0};

    repeat (2) @(negedge clock);
    scramble = 1'b0;
    reset_sweep(1'b1, 1'b0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op(i, tbl[i].inv, tbl[i].wr, tbl[i].other, tbl[i].addr, tbl[i].iidx,
             tbl[i].dw, tbl[i].df, tbl[i].e_wb, tbl[i].e_wba, tbl[i].e_fill,
             tbl[i].e_fa, tbl[i].e_lat, tbl[i].e_wr);
      model_apply(tbl[i].inv, tbl[i].wr, tbl[i].addr, tbl[i].iidx, lix);
      check_line(i, lix);
    end

    // Randomized traffic over a few tags and sets to force conflicts
    for (int i = 0; i < 3; i++) tags[i] = 26'($urandom);
    idxs[0] = 6'h23;
    for (int i = 1; i < 4; i++) idxs[i] = 6'($urandom);
    for (int i = 0; i < 150; i++) begin
      int ti, xi, ii, dw, df;
      bit inv, wr, oth;
      ti  = int'($urandom_range(2, 0));
      xi  = int'($urandom_range(3, 0));
      ii  = int'($urandom_range(3, 0));
      dw  = int'($urandom_range(3, 0));
      df  = int'($urandom_range(3, 0));
      inv = ($urandom_range(5, 0) == 0);
      wr  = 1'($urandom);
      oth = inv && 1'($urandom);
      ra  = {tags[ti], idxs[xi], 4'($urandom)};
      if ($urandom_range(3, 0) == 0) begin
        wb_ack   = 1'b1;
        fill_ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wb_ack   = 1'b0;
        fill_ack = 1'b0;
      end
      model_op(100 + i, inv, wr, oth, ra, idxs[ii], dw, df);
    end

    // Back-to-back hits: one access every two cycles with cpu_req held
    a_addr = {tags[0], 6'h05, 4'h0};
    b_addr = {tags[1], 6'h06, 4'h8};
    model_op(300, 1'b0, 1'b0, 1'b0, a_addr, 6'h00, 0, 1);
    model_op(301, 1'b0, 1'b0, 1'b0, b_addr, 6'h00, 1, 0);
    cpu_req   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = a_addr;
    @(posedge clock);
    @(negedge clock);
    chk("b2b_first_ready", 64'(cpu_ready), 64'd1);
    cpu_addr = b_addr;
    @(posedge clock);
    @(negedge clock);
    chk("b2b_gap_ready", 64'(cpu_ready), 64'd0);
    chk("b2b_idle_index", 64'(tr_index), 64'(b_addr[9:4]));
    @(posedge clock);
    @(negedge clock);
    chk("b2b_second_ready", 64'(cpu_ready), 64'd1);
    chk("b2b_no_write", 64'(tr_write), 64'd0);
    cpu_req = 1'b0;
    @(posedge clock);
    @(negedge clock);

    // Reset in the middle of a fill
    c_addr = {tags[2], 6'h3F, 4'h4};
    model_op(400, 1'b1, 1'b0, 1'b0, 36'h0, 6'h3F, 0, 0);
    cpu_req   = 1'b1;
    cpu_write = 1'b1;
    cpu_addr  = c_addr;
    @(posedge clock);
    @(negedge clock);
    cpu_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      if (fill_req) seen = 1'b1;
      else begin @(posedge clock); @(negedge clock); end
    end
    chk("fill_reached_before_reset", 64'(seen), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("fill_req_drops_on_reset", 64'({fill_req, cpu_ready, tr_write}), 64'd0);
    chk("fill_addr_cleared", 64'(fill_addr), 64'd0);
    reset_sweep(1'b0, 1'b1);
    model_op(401, 1'b0, 1'b0, 1'b0, c_addr, 6'h00, 0, 2);
    model_op(402, 1'b0, 1'b1, 1'b0, c_addr, 6'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
